// File: rtl/toggle_period_monitor_pkg.sv
// Shared definitions for the toggle period monitor: state encoding and default widths.
package toggle_period_monitor_pkg;

    localparam int DEFAULT_W = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        MEASURE = ST_MEASURE,
        LOCKED  = ST_LOCKED
    } state_t;

endpackage

// File: rtl/toggle_period_monitor_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level plus a one-cycle any-edge strobe.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    output logic o_level,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_edge  = r_s2 ^ r_prev;

endmodule

// File: rtl/toggle_period_monitor.sv
// Measures the half-period of an asynchronous toggling input, tracks lock against an
// expected interval and reports loss of signal.
module toggle_period_monitor
    import toggle_period_monitor_pkg::*;
#(
    parameter int W          = DEFAULT_W,
    parameter int EXPECTED   = 1000000,
    parameter int TOL        = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 4000000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_in,
    output logic [W-1:0] o_half_period,
    output logic         o_period_valid,
    output logic         o_match,
    output logic         o_locked,
    output logic         o_timeout,
    output logic [15:0]  o_edge_count
);

    localparam logic [W:0]   EXP_X   = (W+1)'(EXPECTED);
    localparam logic [W:0]   TOL_X   = (W+1)'(TOL);
    localparam logic [W-1:0] CNT_END = W'(TIMEOUT - 1);
    localparam logic [7:0]   LC      = 8'(LOCK_COUNT);

    state_t       r_state;
    logic [W-1:0] r_cnt;
    logic [7:0]   r_mcnt;

    logic         w_edge;
    logic [W:0]   w_n;
    logic         w_win;
    logic [7:0]   w_mcnt_inc;

    sync_edge_detect u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_in    (i_in),
        .o_level (),
        .o_edge  (w_edge)
    );

    // Compare one bit wider than the counter so N+TOL and EXPECTED+TOL cannot wrap.
    assign w_n        = {1'b0, r_cnt} + {{W{1'b0}}, 1'b1};
    assign w_win      = ((w_n + TOL_X) >= EXP_X) && (w_n <= (EXP_X + TOL_X));
    assign w_mcnt_inc = r_mcnt + 8'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_mcnt         <= '0;
            o_half_period  <= '0;
            o_period_valid <= 1'b0;
            o_match        <= 1'b0;
            o_locked       <= 1'b0;
            o_timeout      <= 1'b0;
            o_edge_count   <= '0;
        end else begin
            o_period_valid <= 1'b0;
            o_match        <= 1'b0;
            o_timeout      <= 1'b0;

            if (w_edge) begin
                o_edge_count <= o_edge_count + 16'd1;
                r_cnt        <= '0;
                if (r_state == IDLE) begin
                    r_state <= MEASURE;
                end else begin
                    o_half_period  <= w_n[W-1:0];
                    o_period_valid <= 1'b1;
                    o_match        <= w_win;
                    if (w_win) begin
                        if (r_state == MEASURE) begin
                            if (w_mcnt_inc >= LC) begin
                                r_mcnt   <= LC;
                                o_locked <= 1'b1;
                                r_state  <= LOCKED;
                            end else begin
                                r_mcnt <= w_mcnt_inc;
                            end
                        end
                    end else begin
                        r_mcnt   <= '0;
                        o_locked <= 1'b0;
                        r_state  <= MEASURE;
                    end
                end
            end else if (r_state != IDLE) begin
                // Loss of signal drops back to IDLE so a stuck input pulses only once.
                if (r_cnt == CNT_END) begin
                    o_timeout <= 1'b1;
                    o_locked  <= 1'b0;
                    r_mcnt    <= '0;
                    r_cnt     <= '0;
                    r_state   <= IDLE;
                end else begin
                    r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_toggle_period_monitor.sv
// Randomised self-checking bench for toggle_period_monitor against an event-time model.
module tb_toggle_period_monitor;

    localparam int W   = 32;
    localparam int EXP = 10;
    localparam int TOL = 1;
    localparam int LC  = 4;
    localparam int TO  = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_sig = 1'b0;
    logic [W-1:0] half_period;
    logic         period_valid;
    logic         match;
    logic         locked;
    logic         timeout;
    logic [15:0]  edge_count;

    always #5 clk = ~clk;

    toggle_period_monitor #(
        .W(W), .EXPECTED(EXP), .TOL(TOL), .LOCK_COUNT(LC), .TIMEOUT(TO)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in           (in_sig),
        .o_half_period  (half_period),
        .o_period_valid (period_valid),
        .o_match        (match),
        .o_locked       (locked),
        .o_timeout      (timeout),
        .o_edge_count   (edge_count)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_to   = 0;
    bit sched[int];

    // Model: edges are absolute posedge times; N is the difference of successive times.
    bit          m_active;
    int          m_last;
    int          m_run;
    bit          m_locked;
    logic [31:0] m_hp;
    bit          m_pv, m_match, m_to;
    logic [15:0] m_ec;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    endtask

    task automatic model_reset();
        m_active = 0; m_last = 0; m_run = 0; m_locked = 0;
        m_hp = '0; m_pv = 0; m_match = 0; m_to = 0; m_ec = '0;
    endtask

    task automatic model_step(input int t);
        bit e;
        int n;
        e = sched.exists(t);
        if (e) sched.delete(t);
        m_pv = 0; m_match = 0; m_to = 0;
        if (e) begin
            m_ec = m_ec + 16'd1;
            if (!m_active) begin
                m_active = 1;
            end else begin
                n = t - m_last;
                m_hp = 32'(n);
                m_pv = 1;
                m_match = (n >= EXP - TOL) && (n <= EXP + TOL);
                if (m_match) begin
                    m_run = (m_run + 1 > LC) ? LC : m_run + 1;
                    if (m_run == LC) m_locked = 1;
                end else begin
                    m_run = 0;
                    m_locked = 0;
                end
            end
            m_last = t;
        end else if (m_active && (t - m_last == TO)) begin
            m_to = 1; m_locked = 0; m_run = 0; m_active = 0;
        end
    endtask

    task automatic check_all();
        chk("half_period", 64'(half_period), 64'(m_hp));
        chk("period_valid", 64'(period_valid), 64'(m_pv));
        chk("match", 64'(match), 64'(m_match));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("timeout", 64'(timeout), 64'(m_to));
        chk("edge_count", 64'(edge_count), 64'(m_ec));
        if (timeout) n_to++;
    endtask

    // Input changes at negedge; it is sampled at the next posedge and reported two later.
    task automatic cyc1(input bit tog);
        @(negedge clk);
        if (tog) begin
            in_sig = ~in_sig;
            sched[cyc + 3] = 1'b1;
        end
        @(posedge clk);
        cyc++;
        model_step(cyc);
        #1;
        check_all();
    endtask

    task automatic gap(input int k);
        cyc1(1'b1);
        repeat (k - 1) cyc1(1'b0);
    endtask

    task automatic idle(input int k);
        repeat (k) cyc1(1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hp"}, 64'(half_period), 64'd0);
        chk({tag, "_flags"}, 64'({period_valid, match, locked, timeout}), 64'd0);
        chk({tag, "_ec"}, 64'(edge_count), 64'd0);
    endtask

    initial begin
        int r;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (6) gap(10);
        gap(13);
        repeat (5) gap(10);
        gap(9); gap(11); gap(9); gap(11); gap(8);
        repeat (5) gap(10);

        n_to = 0;
        idle(60);
        chk("timeout_once", 64'(n_to), 64'd1);
        repeat (3) gap(10);

        gap(TO);
        repeat (2) gap(10);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      gap($urandom_range(EXP - TOL - 2, EXP + TOL + 2));
            else if (r < 9) gap($urandom_range(EXP + TOL + 3, TO + 2));
            else            idle($urandom_range(TO + 5, TO + 20));
        end

        repeat (6) gap(10);
        idle(3);
        chk("pre_reset_locked", 64'(locked), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        in_sig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sched.delete();
        model_reset();
        repeat (6) gap(10);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
